int_res_stream_reader: RTL and testbench

Sequential read streamer that sits directly downstream of the intermediate-results memory. It issues strided read bursts on that memory's read port, captures each returned word on the cycle after the request, and buffers it in a small FIFO. Words leave through a valid/ready stream to the compute datapath. It hides the memory's fixed one-cycle read latency and absorbs downstream back-pressure without losing data.

---
 rtl/int_res_stream_reader.sv | 219 +++++++++++++++++++++
 tb/tb_int_res_stream_reader.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_res_stream_reader.sv
// Intermediate-results read streamer: strided bursts from the int-res memory into a valid/ready stream.
// Latency: start in T -> first read T+1 -> first out_valid T+3, then one word per cycle.
// Backpressure: reads throttled so buffered + in-flight words never exceed FIFO_DEPTH; outputs hold while stalled.
// Build option: INT_RES_STREAM_SIGN_EXT_EN sign-extends the low half of SINGLE_WIDTH words.

// Small synchronous FIFO with flush; the caller guarantees no push when full and no pop when empty.
module int_res_stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_dat_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage needs no reset: entries are only observed when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; flush drops everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // A push into a full FIFO without a simultaneous pop means the issue throttle is broken.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push_i && !pop_i) begin
            assert (count_q != CNT_W'(DEPTH));
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
endmodule

module int_res_stream_reader #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LEN_W-1:0]  len,
    input  logic              data_width,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_width,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                width_q, width_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;

    logic                rd_en;
    logic                pop;
    logic                push;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W:0]     fifo_head;
    logic [DATA_W-1:0]   push_word;
    logic [CNT_W:0]      occ_after_pop;

    assign pop  = out_valid & out_ready;
    // A return arriving in the abort cycle belongs to the cancelled burst.
    assign push = inflight_q & ~abort;

    // Space check counts the word already in flight and credits this cycle's pop.
    assign occ_after_pop = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign rd_en = (state_q == S_ISSUE) && (rem_q != '0) &&
                   (occ_after_pop < (CNT_W+1)'(FIFO_DEPTH));

`ifdef INT_RES_STREAM_SIGN_EXT_EN
    localparam int HALF_W = DATA_W / 2;
    assign push_word = width_q ? mem_rd_data
                               : {{(DATA_W-HALF_W){mem_rd_data[HALF_W-1]}}, mem_rd_data[HALF_W-1:0]};
`else
    assign push_word = mem_rd_data;
`endif

    int_res_stream_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (abort),
        .push_i     (push),
        .push_dat_i ({inflight_last_q, push_word}),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    // Next-state: burst latch on start, address/count stepping per issue, abort overrides all.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        width_d  = width_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    stride_d = stride;
                    rem_d    = len;
                    width_d  = data_width;
                    state_d  = (len == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_en) begin
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && fifo_head[DATA_W]) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end
    end

    // The final issue of the burst carries the last tag through the one-cycle memory latency.
    assign inflight_d      = rd_en & ~abort;
    assign inflight_last_d = rd_en & ~abort & (rem_q == LEN_W'(1));

    // State and burst registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            stride_q        <= '0;
            rem_q           <= '0;
            width_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            stride_q        <= stride_d;
            rem_q           <= rem_d;
            width_q         <= width_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign mem_rd_en    = rd_en;
    assign mem_rd_addr  = rd_en ? addr_q : '0;
    assign mem_rd_width = width_q;
    assign out_valid    = ~fifo_empty;
    // Gate the head so stale storage never shows on the stream.
    assign out_data     = out_valid ? fifo_head[DATA_W-1:0] : '0;
    assign out_last     = out_valid & fifo_head[DATA_W];
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
endmodule

// File: tb/tb_int_res_stream_reader.sv
module tb_int_res_stream_reader;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        start, abort, data_width, out_ready;
    logic [14:0] base_addr, stride;
    logic [9:0]  len;
    logic        mem_rd_en, mem_rd_width, out_valid, out_last, busy, done;
    logic [14:0] mem_rd_addr;
    logic [31:0] mem_rd_data, out_data;

    int_res_stream_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .stride(stride), .len(len), .data_width(data_width),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_width(mem_rd_width),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;      // 0 always, 1 one-in-four, 2 random, 3 never
    bit force_en = 0;
    logic [31:0] force_data = '0;
    logic [16:0] gen = '0;

    // Monitor state
    logic [14:0] rd_q[$];
    int          rd_cyc_q[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    int          pop_cyc_q[$];
    int          done_cyc_q[$];
    int first_valid, stall_viol, rule_viol, max_out, issued, popped;
    bit prev_stall;
    logic [31:0] prev_data;
    logic prev_last;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory contents: a tag of the current generation and the address, unless forced.
    function automatic logic [31:0] memval(input logic [14:0] a);
        return force_en ? force_data : {gen, a};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] raw, input logic w);
`ifdef INT_RES_STREAM_SIGN_EXT_EN
        if (!w) return {{16{raw[15]}}, raw[15:0]};
`endif
        return raw;
    endfunction

    function automatic logic [14:0] exp_addr(input logic [14:0] b, input logic [14:0] s, input int i);
        logic [31:0] x;
        x = 32'(b) + 32'(i) * 32'(s);
        return x[14:0];
    endfunction

    // Memory model: one-cycle read latency.
    initial begin
        logic        pend_en;
        logic [14:0] pend_addr;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            pend_en   = mem_rd_en;
            pend_addr = mem_rd_addr;
            @(posedge clk);
            #1;
            mem_rd_data = pend_en ? memval(pend_addr) : $urandom;
        end
    end

    // Consumer ready pattern.
    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Observation of reads, handshakes, stall stability and the issue throttle rule.
    initial begin
        bit pop_now;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                pop_now = out_valid && out_ready;
                if (mem_rd_en) begin
                    if (issued - popped - int'(pop_now) >= DEPTH) rule_viol++;
                    rd_q.push_back(mem_rd_addr);
                    rd_cyc_q.push_back(cyc);
                    issued++;
                end
                if (pop_now) begin
                    out_q.push_back(out_data);
                    last_q.push_back(out_last);
                    pop_cyc_q.push_back(cyc);
                    popped++;
                end
                if (issued - popped > max_out) max_out = issued - popped;
                if (out_valid && first_valid < 0) first_valid = cyc;
                if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                    stall_viol++;
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (done) done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_mon();
        rd_q.delete(); rd_cyc_q.delete(); out_q.delete(); last_q.delete();
        pop_cyc_q.delete(); done_cyc_q.delete();
        first_valid = -1; stall_viol = 0; rule_viol = 0; max_out = 0;
        issued = 0; popped = 0; prev_stall = 0;
    endtask

    task automatic start_burst(input logic [14:0] b, input logic [14:0] s, input logic [9:0] l,
                               input logic w, output int t);
        @(posedge clk);
        #1;
        clear_mon();
        base_addr = b; stride = s; len = l; data_width = w; start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int c, output bit to);
        to = 1'b1;
        c  = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) begin
                c  = cyc;
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; abort = 0; base_addr = '0; stride = '0; len = '0; data_width = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_rd_en, mem_rd_width, mem_rd_addr} !== '0) begin
            n_fail++; $display("FAIL reset_mem: got %h expected 0", {mem_rd_en, mem_rd_width, mem_rd_addr});
        end
        n_checks++;
        if ({out_valid, out_last, out_data} !== '0) begin
            n_fail++; $display("FAIL reset_stream: got %h expected 0", {out_valid, out_last, out_data});
        end
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_status: got %b expected 00", {busy, done});
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_contiguous();
        int t, c; bit to;
        ready_mode = 0; gen = 17'($urandom);
        start_burst(15'h10, 15'd1, 10'd8, 1'b1, t);
        wait_idle(c, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL contig_timeout: busy stuck high"); end
        n_checks++;
        if (rd_q.size() != 8 || out_q.size() != 8) begin
            n_fail++; $display("FAIL contig_count: reads %0d words %0d expected 8/8", rd_q.size(), out_q.size());
        end
        for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
            n_checks++;
            if (rd_q[i] !== 15'(16 + i) || rd_cyc_q[i] != t + 1 + i) begin
                n_fail++; $display("FAIL contig_read%0d: got %h@%0d expected %h@%0d", i, rd_q[i], rd_cyc_q[i], 15'(16 + i), t + 1 + i);
            end
        end
        n_checks++;
        if (first_valid != t + 3) begin
            n_fail++; $display("FAIL contig_first_valid: got cycle %0d expected %0d", first_valid, t + 3);
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_word(memval(15'(16 + i)), 1'b1) || last_q[i] !== (i == 7)) begin
                n_fail++; $display("FAIL contig_word%0d: got %h/%b expected %h/%b", i, out_q[i], last_q[i], exp_word(memval(15'(16 + i)), 1'b1), (i == 7));
            end
        end
        if (pop_cyc_q.size() == 8) begin
            n_checks++;
            if (done_cyc_q.size() != 1 || done_cyc_q[0] != pop_cyc_q[7] + 1 || c != pop_cyc_q[7] + 2) begin
                n_fail++; $display("FAIL contig_done: done pulses %0d, idle at %0d expected 1 pulse at %0d, idle at %0d", done_cyc_q.size(), c, pop_cyc_q[7] + 1, pop_cyc_q[7] + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int t, c; bit to;
        logic [14:0] b, s;
        ready_mode = 1; gen = 17'($urandom);
        b = 15'($urandom); s = 15'($urandom_range(1, 40));
        start_burst(b, s, 10'd16, 1'b1, t);
        wait_idle(c, to);
        n_checks++;
        if (to || out_q.size() != 16 || rd_q.size() != 16) begin
            n_fail++; $display("FAIL bp_count: timeout %b reads %0d words %0d expected 16", to, rd_q.size(), out_q.size());
        end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== memval(exp_addr(b, s, i)) || last_q[i] !== (i == 15)) begin
                n_fail++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, out_q[i], last_q[i], memval(exp_addr(b, s, i)), (i == 15));
            end
        end
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: %0d changes while stalled expected 0", stall_viol); end
        n_checks++;
        if (rule_viol != 0 || max_out != DEPTH) begin
            n_fail++; $display("FAIL bp_throttle: %0d over-issues, peak %0d expected 0, %0d", rule_viol, max_out, DEPTH);
        end
        n_checks++;
        if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", done_cyc_q.size()); end
    endtask

    task automatic test_stride_wrap();
        int t, c; bit to;
        logic [14:0] exp_a[3];
        exp_a[0] = 15'h7FFE; exp_a[1] = 15'h0001; exp_a[2] = 15'h0004;
        ready_mode = 2; gen = 17'($urandom);
        start_burst(15'h7FFE, 15'd3, 10'd3, 1'b1, t);
        wait_idle(c, to);
        n_checks++;
        if (to || rd_q.size() != 3 || out_q.size() != 3) begin
            n_fail++; $display("FAIL wrap_count: timeout %b reads %0d words %0d expected 3", to, rd_q.size(), out_q.size());
        end
        for (int i = 0; i < 3 && i < rd_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (rd_q[i] !== exp_a[i] || out_q[i] !== {gen, exp_a[i]}) begin
                n_fail++; $display("FAIL wrap_%0d: got %h/%h expected %h/%h", i, rd_q[i], out_q[i], exp_a[i], {gen, exp_a[i]});
            end
        end
    endtask

    task automatic test_abort();
        int t, c; bit to;
        ready_mode = 3; gen = 17'($urandom);
        start_burst(15'h100, 15'd1, 10'd16, 1'b1, t);
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pre_valid: got %b expected 1", out_valid); end
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, out_valid, mem_rd_en} !== 3'b000) begin
            n_fail++; $display("FAIL abort_idle: busy/valid/rd_en got %b expected 000", {busy, out_valid, mem_rd_en});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || done_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL abort_flush: valid %b done pulses %0d expected 0/0", out_valid, done_cyc_q.size());
        end
        ready_mode = 0; gen = gen + 17'd1;
        start_burst(15'h200, 15'd2, 10'd4, 1'b1, t);
        wait_idle(c, to);
        n_checks++;
        if (to || out_q.size() != 4) begin
            n_fail++; $display("FAIL abort_fresh_count: timeout %b words %0d expected 4", to, out_q.size());
        end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== memval(exp_addr(15'h200, 15'd2, i))) begin
                n_fail++; $display("FAIL abort_fresh%0d: got %h expected %h", i, out_q[i], memval(exp_addr(15'h200, 15'd2, i)));
            end
        end
    endtask

    task automatic test_empty();
        int t, c; bit to;
        ready_mode = 0;
        start_burst(15'h55, 15'd1, 10'd0, 1'b1, t);
        wait_idle(c, to);
        n_checks++;
        if (to || done_cyc_q.size() != 1 || rd_q.size() != 0 || c != t + 2) begin
            n_fail++; $display("FAIL empty_burst: pulses %0d reads %0d idle %0d expected 1/0/%0d", done_cyc_q.size(), rd_q.size(), c, t + 2);
        end else begin
            n_checks++;
            if (done_cyc_q[0] != t + 1) begin n_fail++; $display("FAIL empty_done: got cycle %0d expected %0d", done_cyc_q[0], t + 1); end
        end
    endtask

    task automatic test_sign_ext();
        int t, c; bit to;
        logic [31:0] exp_s0, exp_s1;
`ifdef INT_RES_STREAM_SIGN_EXT_EN
        exp_s0 = 32'hFFFF_8001; exp_s1 = 32'h0000_7FFF;
`else
        exp_s0 = 32'h0000_8001; exp_s1 = 32'h1234_7FFF;
`endif
        ready_mode = 0; force_en = 1;
        force_data = 32'h0000_8001;
        start_burst(15'h30, 15'd1, 10'd1, 1'b0, t);
        wait_idle(c, to);
        n_checks++;
        if (to || out_q.size() != 1 || out_q[0] !== exp_s0) begin
            n_fail++; $display("FAIL sext_single_neg: words %0d got %h expected %h", out_q.size(), out_q.size() ? out_q[0] : 32'h0, exp_s0);
        end
        force_data = 32'h1234_7FFF;
        start_burst(15'h30, 15'd1, 10'd1, 1'b0, t);
        wait_idle(c, to);
        n_checks++;
        if (to || out_q.size() != 1 || out_q[0] !== exp_s1) begin
            n_fail++; $display("FAIL sext_single_pos: words %0d got %h expected %h", out_q.size(), out_q.size() ? out_q[0] : 32'h0, exp_s1);
        end
        force_data = 32'h0000_8001;
        start_burst(15'h30, 15'd1, 10'd1, 1'b1, t);
        wait_idle(c, to);
        n_checks++;
        if (to || out_q.size() != 1 || out_q[0] !== 32'h0000_8001) begin
            n_fail++; $display("FAIL sext_double: words %0d got %h expected 00008001", out_q.size(), out_q.size() ? out_q[0] : 32'h0);
        end
        force_en = 0;
    endtask

    task automatic test_ignored_start_and_reset();
        int t, c; bit to;
        logic [14:0] b, s;
        ready_mode = 2; gen = 17'($urandom);
        b = 15'($urandom); s = 15'($urandom_range(1, 500));
        start_burst(b, s, 10'd6, 1'b1, t);
        base_addr = b + 15'd77; stride = s + 15'd1; len = 10'd3; data_width = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(c, to);
        n_checks++;
        if (to || rd_q.size() != 6 || out_q.size() != 6 || done_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL ign_start_count: reads %0d words %0d pulses %0d expected 6/6/1", rd_q.size(), out_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < 6 && i < rd_q.size() && i < out_q.size(); i++) begin
            n_checks++;
            if (rd_q[i] !== exp_addr(b, s, i) || out_q[i] !== memval(exp_addr(b, s, i))) begin
                n_fail++; $display("FAIL ign_start_%0d: got %h/%h expected %h/%h", i, rd_q[i], out_q[i], exp_addr(b, s, i), memval(exp_addr(b, s, i)));
            end
        end
        // Reset in the middle of a stalled burst.
        ready_mode = 3;
        start_burst(15'h400, 15'd1, 10'd16, 1'b1, t);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b/%h/%b/%h/%b/%b/%b expected all 0", mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done_cyc_q.size() != 0) begin
            n_fail++; $display("FAIL rst_mid_after: valid %b busy %b pulses %0d expected 0/0/0", out_valid, busy, done_cyc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t, c; bit to;
        logic [14:0] b, s;
        logic [9:0] l;
        logic w;
        for (int k = 0; k < 10; k++) begin
            ready_mode = $urandom_range(0, 2); gen = 17'($urandom);
            b = 15'($urandom); s = 15'($urandom); l = 10'($urandom_range(1, 20)); w = 1'($urandom);
            start_burst(b, s, l, w, t);
            wait_idle(c, to);
            n_checks++;
            if (to || out_q.size() != int'(l) || rd_q.size() != int'(l) || done_cyc_q.size() != 1 || stall_viol != 0 || rule_viol != 0) begin
                n_fail++; $display("FAIL b2b_%0d_summary: words %0d reads %0d pulses %0d stall %0d over %0d expected %0d/%0d/1/0/0", k, out_q.size(), rd_q.size(), done_cyc_q.size(), stall_viol, rule_viol, l, l);
            end
            for (int i = 0; i < int'(l) && i < out_q.size() && i < rd_q.size(); i++) begin
                n_checks++;
                if (rd_q[i] !== exp_addr(b, s, i) || out_q[i] !== exp_word(memval(exp_addr(b, s, i)), w) || last_q[i] !== (i == int'(l) - 1)) begin
                    n_fail++; $display("FAIL b2b_%0d_word%0d: got %h/%h/%b expected %h/%h/%b", k, i, rd_q[i], out_q[i], last_q[i], exp_addr(b, s, i), exp_word(memval(exp_addr(b, s, i)), w), (i == int'(l) - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_backpressure();
        test_stride_wrap();
        test_abort();
        test_empty();
        test_sign_ext();
        test_ignored_start_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
